// File: rtl/uart_file_xfer.sv
// rtl/uart_file_xfer.sv - host-link file transfer engine over a byte-wide UART
// Sends 'R'/'W', the file index (MSB first), then streams a local memory region
// to the host or fills it from the host, closing with a mod-256 checksum byte.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   req_valid/req_ready     request handshake; req_write/file/addr/len describe it
//   done, err               one-cycle completion pulse, error flag alongside done
//   tx_data, tx_en, tx_busy byte transmit strobe towards the UART
//   rx_data, rx_rdy         received-byte strobe from the UART
//   mem_*                   local RAM port, read data valid the cycle after mem_re
module uart_file_xfer #(
    parameter int ADDR_W     = 12,
    parameter int FILE_BYTES = 2,
    parameter int TIMEOUT    = 1000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [8*FILE_BYTES-1:0] req_file,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [ADDR_W:0]         req_len,
    output logic                    done,
    output logic                    err,
    output logic [7:0]              tx_data,
    output logic                    tx_en,
    input  logic                    tx_busy,
    input  logic [7:0]              rx_data,
    input  logic                    rx_rdy,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [7:0]              mem_wdata,
    output logic                    mem_we,
    output logic                    mem_re,
    input  logic [7:0]              mem_rdata
);

    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_IDX, S_TX_WAIT, S_RD_DATA, S_RD_SUM,
        S_WR_FETCH, S_WR_LAT, S_WR_SEND, S_WR_SUM, S_DONE
    } state_t;

    state_t state, state_n, ret_state, ret_n;

    logic                    write_r;
    logic [8*FILE_BYTES-1:0] file_r;
    logic [ADDR_W-1:0]       addr_r;
    logic [ADDR_W:0]         len_r;
    logic [ADDR_W:0]         count;
    logic [ADDR_W:0]         count_inc;
    logic [7:0]              sum;
    logic [7:0]              hold;
    logic [2:0]              idx_cnt;
    logic                    err_flag;
    logic                    wait_first;
    logic [31:0]             idle_cnt;
    logic                    timed_out;
    logic [ADDR_W-1:0]       cur_addr;
    logic [7:0]              idx_byte;

    assign count_inc = count + (ADDR_W+1)'(1);
    assign cur_addr  = addr_r + count[ADDR_W-1:0];

    // idle_cnt holds the number of cycles since the last received byte (or
    // since entering the receive phase), so the abort lands TIMEOUT cycles
    // after the byte that restarted it.
    assign timed_out = (TIMEOUT != 0) && ((idle_cnt + 32'd1) >= 32'(TIMEOUT));

    always_comb begin
        idx_byte = 8'h00;
        for (int i = 0; i < FILE_BYTES; i++) begin
            if (idx_cnt == 3'(FILE_BYTES - 1 - i)) begin
                idx_byte = file_r[8*i +: 8];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            ret_state <= S_IDLE;
        end else begin
            state     <= state_n;
            ret_state <= ret_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        ret_n   = ret_state;
        case (state)
            S_IDLE: begin
                if (req_valid) state_n = S_HDR;
            end
            S_HDR: begin
                if (!tx_busy) begin
                    state_n = S_TX_WAIT;
                    ret_n   = S_IDX;
                end
            end
            S_IDX: begin
                if (!tx_busy) begin
                    state_n = S_TX_WAIT;
                    if (idx_cnt == 3'(FILE_BYTES - 1)) begin
                        if (write_r) ret_n = (len_r == '0) ? S_WR_SUM : S_WR_FETCH;
                        else         ret_n = (len_r == '0) ? S_RD_SUM : S_RD_DATA;
                    end else begin
                        ret_n = S_IDX;
                    end
                end
            end
            S_TX_WAIT: begin
                // The UART raises busy only the cycle after tx_en, so the
                // first cycle here must not trust tx_busy.
                if (!wait_first && !tx_busy) state_n = ret_state;
            end
            S_RD_DATA: begin
                // A byte arriving with the final increment is payload.
                if (rx_rdy) begin
                    if (count_inc == len_r) state_n = S_RD_SUM;
                end else if (timed_out) begin
                    state_n = S_DONE;
                end
            end
            S_RD_SUM: begin
                if (rx_rdy || timed_out) state_n = S_DONE;
            end
            S_WR_FETCH: state_n = S_WR_LAT;
            S_WR_LAT:   state_n = S_WR_SEND;
            S_WR_SEND: begin
                if (!tx_busy) begin
                    state_n = S_TX_WAIT;
                    ret_n   = (count_inc < len_r) ? S_WR_FETCH : S_WR_SUM;
                end
            end
            S_WR_SUM: begin
                if (!tx_busy) begin
                    state_n = S_TX_WAIT;
                    ret_n   = S_DONE;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = (state == S_IDLE);
        done      = 1'b0;
        err       = 1'b0;
        tx_data   = 8'h00;
        tx_en     = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        case (state)
            S_HDR: begin
                if (!tx_busy) begin
                    tx_en   = 1'b1;
                    tx_data = write_r ? 8'h57 : 8'h52;
                end
            end
            S_IDX: begin
                if (!tx_busy) begin
                    tx_en   = 1'b1;
                    tx_data = idx_byte;
                end
            end
            S_RD_DATA: begin
                if (rx_rdy) begin
                    mem_we    = 1'b1;
                    mem_addr  = cur_addr;
                    mem_wdata = rx_data;
                end
            end
            S_WR_FETCH: begin
                mem_re   = 1'b1;
                mem_addr = cur_addr;
            end
            S_WR_SEND: begin
                if (!tx_busy) begin
                    tx_en   = 1'b1;
                    tx_data = hold;
                end
            end
            S_WR_SUM: begin
                if (!tx_busy) begin
                    tx_en   = 1'b1;
                    tx_data = sum;
                end
            end
            S_DONE: begin
                done = 1'b1;
                err  = err_flag;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            write_r    <= 1'b0;
            file_r     <= '0;
            addr_r     <= '0;
            len_r      <= '0;
            count      <= '0;
            sum        <= 8'h00;
            hold       <= 8'h00;
            idx_cnt    <= 3'd0;
            err_flag   <= 1'b0;
            wait_first <= 1'b0;
            idle_cnt   <= 32'd0;
        end else begin
            wait_first <= (state != S_TX_WAIT);

            if (state == S_RD_DATA || state == S_RD_SUM) begin
                idle_cnt <= rx_rdy ? 32'd1 : idle_cnt + 32'd1;
            end else begin
                idle_cnt <= 32'd1;
            end

            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        write_r  <= req_write;
                        file_r   <= req_file;
                        addr_r   <= req_addr;
                        len_r    <= req_len;
                        count    <= '0;
                        sum      <= 8'h00;
                        idx_cnt  <= 3'd0;
                        err_flag <= 1'b0;
                    end
                end
                S_IDX: begin
                    if (!tx_busy) idx_cnt <= idx_cnt + 3'd1;
                end
                S_RD_DATA: begin
                    if (rx_rdy) begin
                        sum   <= sum + rx_data;
                        count <= count_inc;
                    end else if (timed_out) begin
                        err_flag <= 1'b1;
                    end
                end
                S_RD_SUM: begin
                    if (rx_rdy)         err_flag <= (rx_data != sum);
                    else if (timed_out) err_flag <= 1'b1;
                end
                S_WR_LAT: hold <= mem_rdata;
                S_WR_SEND: begin
                    if (!tx_busy) begin
                        sum   <= sum + hold;
                        count <= count_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_file_xfer.sv
// tb/tb_uart_file_xfer.sv - self-checking bench for uart_file_xfer
module tb_uart_file_xfer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [1:0]        req_valid;
    logic              req_write;
    logic [15:0]       req_file;
    logic [11:0]       req_addr;
    logic [12:0]       req_len;
    logic [7:0]        rx_data;
    logic              rx_rdy;

    logic [1:0]        req_ready, done, err, tx_en, tx_busy, mem_we, mem_re;
    logic [1:0][7:0]   tx_data, mem_wdata, mem_rdata;
    logic [1:0][11:0]  mem_addr;

    // dut0: two index bytes, short timeout. dut1: one index byte, no timeout.
    uart_file_xfer #(.ADDR_W(12), .FILE_BYTES(2), .TIMEOUT(50)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write),
        .req_file(req_file), .req_addr(req_addr), .req_len(req_len),
        .done(done[0]), .err(err[0]),
        .tx_data(tx_data[0]), .tx_en(tx_en[0]), .tx_busy(tx_busy[0]),
        .rx_data(rx_data), .rx_rdy(rx_rdy),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_we(mem_we[0]),
        .mem_re(mem_re[0]), .mem_rdata(mem_rdata[0])
    );

    uart_file_xfer #(.ADDR_W(12), .FILE_BYTES(1), .TIMEOUT(0)) u_dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write),
        .req_file(req_file[7:0]), .req_addr(req_addr), .req_len(req_len),
        .done(done[1]), .err(err[1]),
        .tx_data(tx_data[1]), .tx_en(tx_en[1]), .tx_busy(tx_busy[1]),
        .rx_data(rx_data), .rx_rdy(rx_rdy),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_we(mem_we[1]),
        .mem_re(mem_re[1]), .mem_rdata(mem_rdata[1])
    );

    // RAM models with a backdoor preload port
    logic [7:0]  ram [2][4096];
    logic        bd_we = 1'b0;
    int          bd_dut = 0;
    logic [11:0] bd_addr = 12'h0;
    logic [7:0]  bd_data = 8'h0;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_we[d]) ram[d][mem_addr[d]] = mem_wdata[d];
            if (mem_re[d]) mem_rdata[d] <= ram[d][mem_addr[d]];
        end
        if (bd_we) ram[bd_dut][bd_addr] = bd_data;
    end

    // UART transmitter models: busy for 10 cycles starting the cycle after tx_en
    logic [1:0][3:0] busy_cnt;
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset)                busy_cnt[d] <= 4'd0;
            else if (tx_en[d])        busy_cnt[d] <= 4'd10;
            else if (busy_cnt[d] != 0) busy_cnt[d] <= busy_cnt[d] - 4'd1;
        end
    end
    assign tx_busy[0] = (busy_cnt[0] != 4'd0);
    assign tx_busy[1] = (busy_cnt[1] != 4'd0);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act_v, exp_v, cyc);
        end
    endtask

    // Behavioural model state
    logic [7:0]  shadow [2][4096];
    logic [7:0]  exp_tx [$];
    logic [11:0] exp_wa [$];
    logic [7:0]  exp_wd [$];
    logic [7:0]  tx_log [$];
    logic [7:0]  rx_buf [8];
    int          act = 0;
    logic        exp_err = 1'b0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic        last_err = 1'b0;
    int          last_rx_cyc = 0;
    logic [1:0]  acc_prev = 2'b00;
    logic [1:0]  done_prev = 2'b00;

    // Compare process: sampled on the falling edge
    always @(negedge clk) begin
        if (reset) begin
            acc_prev  = 2'b00;
            done_prev = 2'b00;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (acc_prev[d])  chk("req_ready_drop", req_ready[d], 1'b0);
                if (done_prev[d]) chk("req_ready_after_done", req_ready[d], 1'b1);
                if (mem_we[d] || mem_re[d]) chk("mem_we_re_excl", mem_we[d] & mem_re[d], 1'b0);
                if (tx_en[d]) begin
                    chk("tx_en_while_busy", tx_busy[d], 1'b0);
                    chk("tx_dut", d, act);
                    tx_log.push_back(tx_data[d]);
                    chk("tx_expected_avail", exp_tx.size() != 0, 1'b1);
                    if (exp_tx.size() != 0) chk("tx_byte", tx_data[d], exp_tx.pop_front());
                end
                if (mem_we[d]) begin
                    chk("wr_expected_avail", exp_wa.size() != 0, 1'b1);
                    if (exp_wa.size() != 0) begin
                        chk("wr_addr", mem_addr[d], exp_wa.pop_front());
                        chk("wr_data", mem_wdata[d], exp_wd.pop_front());
                    end
                end
                if (done[d]) begin
                    done_cnt++;
                    done_cyc = cyc;
                    last_err = err[d];
                    chk("done_dut", d, act);
                    chk("done_err", err[d], exp_err);
                    chk("tx_left_at_done", exp_tx.size(), 0);
                    chk("wr_left_at_done", exp_wa.size(), 0);
                    chk("req_ready_in_done", req_ready[d], 1'b0);
                end else if (err[d]) begin
                    chk("err_without_done", err[d], 1'b0);
                end
                acc_prev[d]  = req_valid[d] & req_ready[d];
                done_prev[d] = done[d];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input int d, input logic [11:0] a, input logic [7:0] v);
        step();
        bd_we = 1'b1; bd_dut = d; bd_addr = a; bd_data = v;
        shadow[d][a] = v;
        step();
        bd_we = 1'b0;
    endtask

    // Expected tx bytes, RAM writes and error flag from the protocol rules
    task automatic plan(input int d, input bit wr, input logic [15:0] file,
                        input logic [11:0] addr, input logic [12:0] len, input int n_rx);
        int         fb;
        logic [7:0] s;
        logic [11:0] a;
        exp_tx.delete(); exp_wa.delete(); exp_wd.delete(); tx_log.delete();
        act = d;
        fb  = (d == 0) ? 2 : 1;
        s   = 8'h00;
        exp_tx.push_back(wr ? 8'h57 : 8'h52);
        for (int i = fb - 1; i >= 0; i--) exp_tx.push_back(8'(file >> (8 * i)));
        if (wr) begin
            for (int i = 0; i < int'(len); i++) begin
                a = addr + 12'(i);
                exp_tx.push_back(shadow[d][a]);
                s = s + shadow[d][a];
            end
            exp_tx.push_back(s);
            exp_err = 1'b0;
        end else begin
            for (int i = 0; i < int'(len) && i < n_rx; i++) begin
                a = addr + 12'(i);
                exp_wa.push_back(a);
                exp_wd.push_back(rx_buf[i]);
                shadow[d][a] = rx_buf[i];
                s = s + rx_buf[i];
            end
            exp_err = (n_rx <= int'(len)) ? 1'b1 : (rx_buf[len] != s);
        end
    endtask

    task automatic issue(input int d, input bit wr, input logic [15:0] file,
                         input logic [11:0] addr, input logic [12:0] len);
        chk("req_ready_idle", req_ready[d], 1'b1);
        req_write = wr; req_file = file; req_addr = addr; req_len = len;
        req_valid[d] = 1'b1;
        step();
        req_valid = 2'b00;
    endtask

    task automatic feed_rx(input int d, input int n);
        int i;
        for (i = 0; i < 2000 && exp_tx.size() != 0; i++) step();
        chk("hdr_sent_in_time", exp_tx.size(), 0);
        for (i = 0; i < 100 && tx_busy[d]; i++) step();
        step();
        step();
        for (int k = 0; k < n; k++) begin
            rx_data = rx_buf[k];
            rx_rdy  = 1'b1;
            last_rx_cyc = cyc;
            step();
            rx_rdy = 1'b0;
            repeat (3) step();
        end
    endtask

    task automatic wait_done(input int n0);
        for (int i = 0; i < 3000 && done_cnt == n0; i++) step();
        chk("done_seen", done_cnt != n0, 1'b1);
        repeat (3) step();
        chk("done_pulses", done_cnt - n0, 1);
    endtask

    task automatic chk_log(input string name, input logic [63:0] lit, input int n);
        chk({name, "_len"}, tx_log.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < tx_log.size()) chk(name, tx_log[i], lit[8*(n-1-i) +: 8]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int n0;
        int cnt;
        reset = 1'b1; req_valid = 2'b00; req_write = 1'b0; req_file = 16'h0;
        req_addr = 12'h0; req_len = 13'h0; rx_data = 8'h0; rx_rdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_req_ready", req_ready[d], 1'b1);
            chk("rst_done", done[d], 1'b0);
            chk("rst_err", err[d], 1'b0);
            chk("rst_tx_en", tx_en[d], 1'b0);
            chk("rst_mem_we", mem_we[d], 1'b0);
            chk("rst_mem_re", mem_re[d], 1'b0);
            chk("rst_tx_data", tx_data[d], 8'h00);
            chk("rst_mem_addr", mem_addr[d], 12'h000);
            chk("rst_mem_wdata", mem_wdata[d], 8'h00);
        end
        step();
        reset = 1'b0;
        step();

        // Write: file 0x0021, three bytes from 0x310
        poke(0, 12'h310, 8'h05); poke(0, 12'h311, 8'h10); poke(0, 12'h312, 8'hFF);
        plan(0, 1'b1, 16'h0021, 12'h310, 13'd3, 0);
        n0 = done_cnt;
        issue(0, 1'b1, 16'h0021, 12'h310, 13'd3);
        wait_done(n0);
        chk_log("wr_tx_seq", 64'h57_00_21_05_10_FF_14, 7);
        chk("wr_err", last_err, 1'b0);

        // Read: good checksum
        rx_buf[0] = 8'h7F; rx_buf[1] = 8'h01; rx_buf[2] = 8'h80;
        plan(0, 1'b0, 16'h0961, 12'h620, 13'd2, 3);
        n0 = done_cnt;
        issue(0, 1'b0, 16'h0961, 12'h620, 13'd2);
        feed_rx(0, 3);
        wait_done(n0);
        chk_log("rd_tx_seq", 64'h52_09_61, 3);
        chk("rd_ram0", ram[0][12'h620], 8'h7F);
        chk("rd_ram1", ram[0][12'h621], 8'h01);
        chk("rd_err", last_err, 1'b0);

        // Read: bad checksum, data still lands in RAM
        rx_buf[2] = 8'h81;
        plan(0, 1'b0, 16'h0961, 12'h630, 13'd2, 3);
        n0 = done_cnt;
        issue(0, 1'b0, 16'h0961, 12'h630, 13'd2);
        feed_rx(0, 3);
        wait_done(n0);
        chk("badsum_ram0", ram[0][12'h630], 8'h7F);
        chk("badsum_ram1", ram[0][12'h631], 8'h01);
        chk("badsum_err", last_err, 1'b1);

        // Read: timeout after two of four payload bytes
        rx_buf[0] = 8'h11; rx_buf[1] = 8'h22;
        plan(0, 1'b0, 16'h0102, 12'h100, 13'd4, 2);
        n0 = done_cnt;
        issue(0, 1'b0, 16'h0102, 12'h100, 13'd4);
        feed_rx(0, 2);
        wait_done(n0);
        chk("timeout_delay", done_cyc - last_rx_cyc, 50);
        chk("timeout_err", last_err, 1'b1);
        chk("timeout_ram0", ram[0][12'h100], 8'h11);
        chk("timeout_ram1", ram[0][12'h101], 8'h22);

        // Write wrapping past the top of memory, one index byte
        poke(1, 12'hFFF, 8'hA5); poke(1, 12'h000, 8'h5A);
        plan(1, 1'b1, 16'h003C, 12'hFFF, 13'd2, 0);
        n0 = done_cnt;
        issue(1, 1'b1, 16'h003C, 12'hFFF, 13'd2);
        wait_done(n0);
        chk_log("wrap_tx_seq", 64'h57_3C_A5_5A_FF, 5);
        chk("wrap_err", last_err, 1'b0);

        // Reset while sending the first payload byte aborts silently
        plan(0, 1'b1, 16'h0021, 12'h310, 13'd3, 0);
        n0 = done_cnt;
        issue(0, 1'b1, 16'h0021, 12'h310, 13'd3);
        cnt = 0;
        for (int i = 0; i < 500 && cnt < 4; i++) begin
            if (tx_en[0]) cnt++;
            if (cnt < 4) step();
        end
        chk("abort_reached_payload", cnt, 4);
        reset = 1'b1;
        step();
        step();
        exp_tx.delete(); exp_wa.delete(); exp_wd.delete();
        reset = 1'b0;
        repeat (30) step();
        chk("abort_no_done", done_cnt, n0);

        // Fresh zero-length read after the abort
        rx_buf[0] = 8'h00;
        plan(0, 1'b0, 16'h0961, 12'h050, 13'd0, 1);
        n0 = done_cnt;
        issue(0, 1'b0, 16'h0961, 12'h050, 13'd0);
        feed_rx(0, 1);
        wait_done(n0);
        chk_log("len0_tx_seq", 64'h52_09_61, 3);
        chk("len0_err", last_err, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_file_xfer.md
Name: uart_file_xfer

Overview:
- Parametrised host-link transfer engine for the MNIST accelerator.
- Moves one "file" (a contiguous byte region of local feature/weight memory) between the host and on-chip RAM over the byte-wide rs232 interface.
- Per request, it sends the header 'R'/'W', then a FILE_BYTES-wide file index (MSB first), then streams LEN payload bytes followed by a mod-256 checksum.
- Adds configurable index width, memory depth, synchronous-RAM read latency handling, checksum checking and an rx timeout.

Parameters:
ADDR_W, 12, local memory address width (depth 2^ADDR_W bytes)
FILE_BYTES, 2, number of file-index bytes sent after header (1..4)
TIMEOUT, 1000000, max clk cycles between received bytes; 0 disables timeout

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
req_valid  in  1  request strobe
req_ready  out  1  engine idle, request accepted when req_valid&req_ready
req_write  in  1  1 = PE->host (header 'W' 0x57), 0 = host->PE (header 'R' 0x52)
req_file  in  8*FILE_BYTES  file index
req_addr  in  ADDR_W  first local memory address
req_len  in  ADDR_W+1  payload byte count (0 allowed)
done  out  1  one-cycle pulse at end of a transfer
err  out  1  one-cycle pulse together with done on checksum mismatch or timeout
tx_data  out  8  byte to UART
tx_en  out  1  one-cycle transmit strobe
tx_busy  in  1  UART transmitter busy
rx_data  in  8  received byte
rx_rdy  in  1  one-cycle received-byte strobe
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  8  RAM write data
mem_we  out  1  RAM write enable
mem_re  out  1  RAM read enable; mem_rdata valid the following cycle
mem_rdata  in  8  RAM read data

Behaviour:
- Reset: state IDLE; req_ready=1; done=err=tx_en=mem_we=mem_re=0; tx_data, mem_addr and mem_wdata = 0; counters and checksum = 0. Reset mid-transfer aborts immediately, with no done pulse.
- Request capture (IDLE & req_valid): latch write, file, addr, len. req_ready drops the next cycle and stays 0 until the cycle after done.
- TX handshake, used for every sent byte:
  - In a send state, when tx_busy=0, drive tx_data and pulse tx_en for one cycle, then enter TX_WAIT.
  - TX_WAIT ignores tx_busy for exactly one cycle, because the UART raises busy the cycle after tx_en.
  - It then waits for tx_busy=0 and returns to the calling state.
- States:
  - IDLE.
  - HDR: send 0x52/0x57.
  - IDX: send FILE_BYTES bytes of file, MSB first.
  - Branch on write.
- Read path (write=0):
  - RD_DATA: on each rx_rdy, mem_we=1 for one cycle with mem_addr=addr+count, mem_wdata=rx_data; sum+=rx_data; count+=1.
  - When count==len, go to RD_SUM.
  - RD_SUM: the next rx_rdy byte is compared with sum[7:0]; then DONE, with err=1 if they differ.
- Write path (write=1):
  - WR_FETCH: mem_re=1, mem_addr=addr+count.
  - WR_LAT: one cycle; capture mem_rdata into a holding register.
  - WR_SEND: transmit the held byte; sum+=byte; count+=1. Loop to WR_FETCH while count<len, otherwise go to WR_SUM.
  - WR_SUM: transmit sum[7:0], then DONE.
- len==0: no payload. Read receives only the checksum byte (expected 0x00); write sends 0x00.
- Address arithmetic: addr+count computed mod 2^ADDR_W (wraps past top of memory). Sum is 8-bit wrap-around.
- Timeout (TIMEOUT>0, read path only):
  - The idle counter resets on every rx_rdy and on entry to RD_DATA.
  - When the counter reaches TIMEOUT, go to DONE with err=1. Bytes already written remain in RAM.
- rx_rdy outside RD_DATA/RD_SUM is ignored.
- rx_rdy coinciding with the final count increment: that byte is the payload's last byte, not the checksum.
- DONE: done=1 (and err if flagged) for one cycle, then IDLE.
- Only one of mem_we/mem_re is ever high in a cycle. tx_en is never asserted while tx_busy=1.

Test Plan:
- Write file 0x0021, addr 0x310, len 3, RAM[0x310..312]={0x05,0x10,0xFF}, UART busy 10 cycles per byte -> tx sequence 0x57,0x00,0x21,0x05,0x10,0xFF,0x14; one done pulse, err=0.
- Read file 0x0961, addr 0x620, len 2, rx bytes 0x7F,0x01,0x80 -> tx 0x52,0x09,0x61; RAM[0x620]=0x7F, RAM[0x621]=0x01; done=1, err=0.
- Same read with checksum byte 0x81 -> RAM still written; done and err pulse together.
- Read len 4 with TIMEOUT=50, only 2 bytes sent -> done+err exactly 50 cycles after the second rx_rdy; req_ready=1 next cycle.
- Write addr 0xFFF, len 2 (ADDR_W=12), FILE_BYTES=1 -> header, 1 index byte, then bytes from RAM[0xFFF] and RAM[0x000].
- Reset asserted during WR_SEND, then a new read request with len 0 and rx 0x00 -> no done for the aborted transfer; clean 0x52+index, done err=0.
